// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen: 1024x768@60 raster timing generator for a 65 MHz pixel clock.
// Waits for a synchronized PLL lock, then runs h/v counters and produces
// registered sync, blanking and pixel-coordinate outputs (one cycle behind the
// counters). Optional colour-bar test pattern enabled by macro VGA_TEST_PATTERN_EN.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   pll_locked   PLL lock, asynchronous to clk
//   hsync/vsync  sync outputs, polarity set by H_SYNC_POL / V_SYNC_POL
//   de           data enable, high in the active region
//   pix_x/pix_y  active-region coordinates, 0 outside it
//   line_start   pulse at h_cnt==0
//   frame_start  pulse at h_cnt==0, v_cnt==0
//   running      raster is advancing
//   rgb          (VGA_TEST_PATTERN_EN only) colour bars, aligned with de
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 1024,
  parameter int unsigned H_FP       = 24,
  parameter int unsigned H_SYNC     = 136,
  parameter int unsigned H_BP       = 160,
  parameter int unsigned V_ACTIVE   = 768,
  parameter int unsigned V_FP       = 3,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BP       = 29,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_locked,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        running
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [23:0] rgb
`endif
);

  localparam int unsigned H_W      = 11;
  localparam int unsigned V_W      = 10;
  localparam int unsigned HX_W     = H_W + 1;
  localparam int unsigned VX_W     = V_W + 1;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Elaboration-time guard: totals must fit the counters.
  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic        lock_meta;
  logic        lock_s;
  state_t      state;
  state_t      next_state;
  logic        run_c;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  logic        hsync_c;
  logic        vsync_c;
  logic        de_c;
  logic [10:0] pix_x_c;
  logic [9:0]  pix_y_c;
  logic        line_start_c;
  logic        frame_start_c;

  // Two-flop synchronizer for the asynchronous lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (lock_s)  next_state = RUN;
      RUN:     if (!lock_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM output decode: a lock drop takes effect on the edge that sees it.
  always_comb begin
    run_c = (next_state == RUN);
  end

  // Raster counters; held at the origin whenever not running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run_c) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_W'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_W'(V_TOTAL - 1)) ? '0 : v_cnt + V_W'(1);
    end else begin
      h_cnt <= h_cnt + H_W'(1);
    end
  end

  // Next values of the output registers, derived from the current counters.
  always_comb begin
    hsync_c       = ~H_SYNC_POL;
    vsync_c       = ~V_SYNC_POL;
    de_c          = 1'b0;
    pix_x_c       = '0;
    pix_y_c       = '0;
    line_start_c  = 1'b0;
    frame_start_c = 1'b0;
    if (run_c) begin
      de_c = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
      // One extra bit on the upper bound so HS_END/VS_END == 2^W still compares correctly.
      if (h_cnt >= H_W'(HS_START) && {1'b0, h_cnt} < HX_W'(HS_END)) hsync_c = H_SYNC_POL;
      if (v_cnt >= V_W'(VS_START) && {1'b0, v_cnt} < VX_W'(VS_END)) vsync_c = V_SYNC_POL;
      if (de_c) begin
        pix_x_c = h_cnt;
        pix_y_c = v_cnt;
      end
      line_start_c  = (h_cnt == '0);
      frame_start_c = (h_cnt == '0) && (v_cnt == '0);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  if (BAR_W == 0) begin : g_bad_bar
    $error("vga_timing_gen: H_ACTIVE too small for colour bars");
  end

  logic [2:0]  bar_c;
  logic [23:0] rgb_c;

  // Colour bar lookup, blanked outside the active region.
  always_comb begin
    bar_c = 3'(h_cnt / H_W'(BAR_W));
    rgb_c = 24'h000000;
    if (de_c) begin
      case (bar_c)
        3'd0:    rgb_c = 24'hFFFFFF;
        3'd1:    rgb_c = 24'hFFFF00;
        3'd2:    rgb_c = 24'h00FFFF;
        3'd3:    rgb_c = 24'h00FF00;
        3'd4:    rgb_c = 24'hFF00FF;
        3'd5:    rgb_c = 24'hFF0000;
        3'd6:    rgb_c = 24'h0000FF;
        default: rgb_c = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb <= 24'h000000;
    else        rgb <= rgb_c;
  end
`endif

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      hsync       <= hsync_c;
      vsync       <= vsync_c;
      de          <= de_c;
      pix_x       <= pix_x_c;
      pix_y       <= pix_y_c;
      line_start  <= line_start_c;
      frame_start <= frame_start_c;
      running     <= run_c;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen: a full-size instance and a reduced-timing instance
// driven by the same clock, reset and lock, both compared every cycle against
// a cycle-count model of the raster.
module tb_vga_timing_gen;

  localparam int unsigned DHA = 1024, DHF = 24, DHS = 136, DHB = 160;
  localparam int unsigned DVA = 768,  DVF = 3,  DVS = 6,   DVB = 29;
  localparam int unsigned SHA = 16, SHF = 2, SHS = 3, SHB = 3;
  localparam int unsigned SVA = 4,  SVF = 1, SVS = 2, SVB = 1;
  localparam int unsigned D_FRAME = 1344 * 806;
  localparam int unsigned S_FRAME = 24 * 8;

  localparam logic [23:0] BARS [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [10:0] px;
    logic [9:0]  py;
    logic        ls;
    logic        fs;
    logic        run;
    logic [23:0] rgb;
  } out_t;

  logic clk;
  logic rst_n;
  logic pll_locked;

  logic d_hsync, d_vsync, d_de, d_line_start, d_frame_start, d_running;
  logic [10:0] d_pix_x;
  logic [9:0]  d_pix_y;
  logic s_hsync, s_vsync, s_de, s_line_start, s_frame_start, s_running;
  logic [10:0] s_pix_x;
  logic [9:0]  s_pix_y;
  logic [23:0] d_rgb, s_rgb;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .pix_x(d_pix_x), .pix_y(d_pix_y),
    .line_start(d_line_start), .frame_start(d_frame_start), .running(d_running)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(d_rgb)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .pix_x(s_pix_x), .pix_y(s_pix_y),
    .line_start(s_line_start), .frame_start(s_frame_start), .running(s_running)
`ifdef VGA_TEST_PATTERN_EN
    , .rgb(s_rgb)
`endif
  );

`ifndef VGA_TEST_PATTERN_EN
  assign d_rgb = 24'h0;
  assign s_rgb = 24'h0;
`endif

  // Expected outputs for a raster that has been running for t cycles.
  function automatic out_t model_out(input int unsigned t,
                                     input int unsigned ha, hf, hs, hb,
                                     input int unsigned va, vf, vs, vb,
                                     input bit active);
    out_t o;
    int unsigned ht, vt, h, v;
    o = '0;
    o.hsync = 1'b1;
    o.vsync = 1'b1;
    if (!active) return o;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h = t % ht;
    v = (t / ht) % vt;
    o.de    = (h < ha) && (v < va);
    o.hsync = !((h >= ha + hf) && (h < ha + hf + hs));
    o.vsync = !((v >= va + vf) && (v < va + vf + vs));
    o.px    = o.de ? 11'(h) : 11'd0;
    o.py    = o.de ? 10'(v) : 10'd0;
    o.ls    = (h == 0);
    o.fs    = (h == 0) && (v == 0);
    o.run   = 1'b1;
    o.rgb   = o.de ? BARS[h / (ha / 8)] : 24'h0;
    return o;
  endfunction

  function automatic logic [26:0] core(input out_t o);
    return {o.hsync, o.vsync, o.de, o.px, o.py, o.ls, o.fs, o.run};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Model: lock seen through two samples, raster age t counts while running.
  bit ls1, ls2;
  int unsigned t_d, t_s;
  out_t exp_d, exp_s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls1 = 1'b0; ls2 = 1'b0; t_d = 0; t_s = 0;
      exp_d = model_out(0, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b0);
      exp_s = exp_d;
    end else begin
      exp_d = model_out(t_d, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, ls2);
      exp_s = model_out(t_s, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, ls2);
      if (ls2) begin
        t_d = (t_d + 1) % D_FRAME;
        t_s = (t_s + 1) % S_FRAME;
      end else begin
        t_d = 0;
        t_s = 0;
      end
      ls2 = ls1;
      ls1 = pll_locked;
    end
  end

  out_t got_d, got_s;
  assign got_d = {d_hsync, d_vsync, d_de, d_pix_x, d_pix_y, d_line_start, d_frame_start, d_running, d_rgb};
  assign got_s = {s_hsync, s_vsync, s_de, s_pix_x, s_pix_y, s_line_start, s_frame_start, s_running, s_rgb};

  // Line statistics on the full-size instance, frame statistics on the small one.
  bit d_seen = 0, s_seen = 0;
  int d_per, d_de_n, d_hs_n, d_hs_off;
  int s_per, s_de_n, s_vs_n, s_vs_off;

  always @(negedge clk) begin
    check("dflt_outputs", 32'(core(got_d)), 32'(core(exp_d)));
    check("small_outputs", 32'(core(got_s)), 32'(core(exp_s)));
`ifdef VGA_TEST_PATTERN_EN
    check("dflt_rgb", 32'(got_d.rgb), 32'(exp_d.rgb));
    check("small_rgb", 32'(got_s.rgb), 32'(exp_s.rgb));
`endif
    if (!d_running) d_seen = 0;
    else begin
      if (d_line_start) begin
        if (d_seen) begin
          check("line_period", d_per, 1344);
          check("line_de_high", d_de_n, 1024);
          check("line_hsync_low", d_hs_n, 136);
          check("line_hsync_offset", d_hs_off, 1048);
        end
        d_seen = 1; d_per = 0; d_de_n = 0; d_hs_n = 0; d_hs_off = 0;
      end
      if (d_seen) begin
        if (d_de) d_de_n++;
        if (!d_hsync) begin
          if (d_hs_n == 0) d_hs_off = d_per;
          d_hs_n++;
        end
        d_per++;
      end
    end
    if (!s_running) s_seen = 0;
    else begin
      if (s_frame_start) begin
        if (s_seen) begin
          check("frame_period", s_per, 192);
          check("frame_de_high", s_de_n, 64);
          check("frame_vsync_low", s_vs_n, 48);
          check("frame_vsync_offset", s_vs_off, 120);
        end
        s_seen = 1; s_per = 0; s_de_n = 0; s_vs_n = 0; s_vs_off = 0;
      end
      if (s_seen) begin
        if (s_de) s_de_n++;
        if (!s_vsync) begin
          if (s_vs_n == 0) s_vs_off = s_per;
          s_vs_n++;
        end
        s_per++;
      end
    end
  end

  // Wait for running, then the first output must be the frame origin.
  task automatic startup_check(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!d_running && n < 10);
    check({tag, "_run_latency_le3"}, 32'(n <= 3), 32'd1);
    check({tag, "_first_out_dflt"}, {8'd0, d_frame_start, d_de, d_pix_x, d_pix_y},
          {8'd0, 1'b1, 1'b1, 11'd0, 10'd0});
    check({tag, "_first_out_small"}, {8'd0, s_frame_start, s_de, s_pix_x, s_pix_y},
          {8'd0, 1'b1, 1'b1, 11'd0, 10'd0});
  endtask

  task automatic async_reset(input bit do_start);
    @(posedge clk);
    #($urandom_range(1, 4));
    rst_n = 1'b0;
    #1;
    check("async_rst_dflt", 32'({d_hsync, d_vsync, d_de, d_pix_x, d_pix_y, d_line_start, d_frame_start, d_running}),
          32'({2'b11, 25'd0}));
    check("async_rst_small", 32'({s_hsync, s_vsync, s_de, s_pix_x, s_pix_y, s_line_start, s_frame_start, s_running}),
          32'({2'b11, 25'd0}));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    if (do_start) startup_check("rst_restart");
  endtask

  out_t m;
  initial begin
    int k;
    rst_n = 1'b0;
    pll_locked = 1'b1;

    // Pin the model with hand-computed values for the full-size timing.
    m = model_out(1047, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_h1047_hsync", 32'(m.hsync), 32'd1);
    m = model_out(1048, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_h1048_hsync", 32'(m.hsync), 32'd0);
    m = model_out(1183, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_h1183_hsync", 32'(m.hsync), 32'd0);
    m = model_out(1184, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_h1184_hsync", 32'(m.hsync), 32'd1);
    m = model_out(1023, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_h1023", 32'({m.de, m.px}), 32'({1'b1, 11'd1023}));
    m = model_out(1024, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_h1024", 32'({m.de, m.px}), 32'd0);
    m = model_out(771 * 1344 - 1, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_v770_vsync", 32'(m.vsync), 32'd1);
    m = model_out(771 * 1344, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_v771_vsync", 32'({m.vsync, m.de}), 32'd0);
    m = model_out(777 * 1344, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_v777_vsync", 32'(m.vsync), 32'd1);
    m = model_out(806 * 1344, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_frame_wrap", 32'({m.fs, m.de, m.px, m.py}), 32'({2'b11, 21'd0}));
`ifdef VGA_TEST_PATTERN_EN
    m = model_out(0, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_rgb_x0", 32'(m.rgb), 32'hFFFFFF);
    m = model_out(128, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_rgb_x128", 32'(m.rgb), 32'hFFFF00);
    m = model_out(1023, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_rgb_x1023", 32'(m.rgb), 32'h000000);
    m = model_out(1030, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB, 1'b1);
    check("model_rgb_h1030", 32'(m.rgb), 32'h000000);
`endif

    // Reset with lock already high.
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    startup_check("boot");

    // Run to line 2, then drop lock mid-line.
    k = 0;
    while (!(d_de && d_pix_y == 10'd2) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("reach_line2", 32'(k < 5000), 32'd1);
    repeat (500) @(negedge clk);
    #1 pll_locked = 1'b0;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!(!d_running && d_hsync && d_vsync && !d_de) && k < 10);
    check("lock_drop_latency_le3", 32'(k <= 3), 32'd1);
    repeat ($urandom_range(2, 6)) @(negedge clk);
    #1 pll_locked = 1'b1;
    startup_check("relock");
    repeat (3000) @(negedge clk);

    async_reset(1'b1);
    repeat (1500) @(negedge clk);

    // Randomized lock glitches, drops and resets.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 700)) @(negedge clk);
      case ($urandom_range(0, 3))
        0: begin
          #1 pll_locked = 1'b0;
          #3 pll_locked = 1'b1;
        end
        1: begin
          #1 pll_locked = 1'b0;
          repeat ($urandom_range(1, 8)) @(negedge clk);
          #1 pll_locked = 1'b1;
        end
        2: async_reset(1'b0);
        default: ;
      endcase
    end
    repeat (2800) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
